// File: rtl/uart_rx.sv
// uart_rx: UART receive engine.
// Synchronises the serial line, finds the start edge, samples each bit at
// mid-period using an OVS-times oversampling tick, and emits single-cycle
// done / parity-error / framing-error pulses.
// Optional idle-line timeout is built when UART_RX_IDLE_TIMEOUT_EN is defined.
module uart_rx #(
   parameter int DIV_WIDTH   = 16,
   parameter int OVS         = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 i_clk,
   input  logic                 i_nrst,
   input  logic                 i_rx,
   input  logic                 i_enable,
   input  logic [DIV_WIDTH-1:0] i_baud_div,
   input  logic [1:0]           i_data_bits,
   input  logic                 i_parity_en,
   input  logic                 i_parity_odd,
   input  logic                 i_stop_bits,
   output logic [7:0]           o_data,
   output logic                 o_valid,
   output logic                 o_parity_error,
   output logic                 o_bad_frame,
   output logic                 o_busy
`ifdef UART_RX_IDLE_TIMEOUT_EN
   ,
   input  logic [7:0]           i_timeout_bits,
   output logic                 o_timeout
`endif
);

   localparam int            PW    = $clog2(OVS);
   localparam logic [PW-1:0] MID   = PW'(OVS / 2 - 1);
   localparam logic [PW-1:0] LAST  = PW'(OVS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP1,
      ST_STOP2
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
   logic [PW-1:0]          phase_q, phase_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             shift_q, shift_d;
   logic                   par_acc_q, par_acc_d;
   logic                   par_err_q, par_err_d;
   logic                   frm_err_q, frm_err_d;
   logic [1:0]             cfg_bits_q, cfg_bits_d;
   logic                   cfg_par_en_q, cfg_par_en_d;
   logic                   cfg_par_odd_q, cfg_par_odd_d;
   logic                   cfg_stop2_q, cfg_stop2_d;
   logic [7:0]             data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   perr_out_q, perr_out_d;
   logic                   ferr_out_q, ferr_out_d;

   logic                   rx_s;
   logic                   tick;
   logic                   mid_sample;
   logic                   start_edge;
   logic                   complete;
   logic [2:0]             last_bit;

   assign rx_s       = sync_q[SYNC_STAGES-1];
   // >= rather than == so a divider lowered mid-count cannot strand the counter
   assign tick       = (div_cnt_q >= i_baud_div);
   assign mid_sample = tick && (phase_q == MID);
   assign start_edge = (state_q == ST_IDLE) && i_enable && prev_q && !rx_s;
   assign last_bit   = 3'd4 + {1'b0, cfg_bits_q};

   // Metastability chain on the raw line plus one flop of history for edge detection
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
         prev_q <= rx_s;
      end
   end

   // Frame state, counters, datapath and output pulse registers
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q       <= ST_IDLE;
         div_cnt_q     <= '0;
         phase_q       <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         par_acc_q     <= 1'b0;
         par_err_q     <= 1'b0;
         frm_err_q     <= 1'b0;
         cfg_bits_q    <= '0;
         cfg_par_en_q  <= 1'b0;
         cfg_par_odd_q <= 1'b0;
         cfg_stop2_q   <= 1'b0;
         data_q        <= '0;
         valid_q       <= 1'b0;
         perr_out_q    <= 1'b0;
         ferr_out_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         div_cnt_q     <= div_cnt_d;
         phase_q       <= phase_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         par_acc_q     <= par_acc_d;
         par_err_q     <= par_err_d;
         frm_err_q     <= frm_err_d;
         cfg_bits_q    <= cfg_bits_d;
         cfg_par_en_q  <= cfg_par_en_d;
         cfg_par_odd_q <= cfg_par_odd_d;
         cfg_stop2_q   <= cfg_stop2_d;
         data_q        <= data_d;
         valid_q       <= valid_d;
         perr_out_q    <= perr_out_d;
         ferr_out_q    <= ferr_out_d;
      end
   end

   // Next-state logic: baud/phase counters, bit sampling and frame completion
   always_comb begin
      state_d       = state_q;
      div_cnt_d     = div_cnt_q;
      phase_d       = phase_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      par_acc_d     = par_acc_q;
      par_err_d     = par_err_q;
      frm_err_d     = frm_err_q;
      cfg_bits_d    = cfg_bits_q;
      cfg_par_en_d  = cfg_par_en_q;
      cfg_par_odd_d = cfg_par_odd_q;
      cfg_stop2_d   = cfg_stop2_q;
      data_d        = data_q;
      valid_d       = 1'b0;
      perr_out_d    = 1'b0;
      ferr_out_d    = 1'b0;
      complete      = 1'b0;

      // Free-running oversampling tick; phase wraps naturally at OVS-1
      if (tick) begin
         div_cnt_d = '0;
         phase_d   = phase_q + PW'(1);
      end else begin
         div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (start_edge) begin
               // Align the sampling phase to the edge and freeze the frame format
               state_d       = ST_START;
               div_cnt_d     = '0;
               phase_d       = '0;
               bit_cnt_d     = '0;
               shift_d       = '0;
               par_acc_d     = 1'b0;
               par_err_d     = 1'b0;
               frm_err_d     = 1'b0;
               cfg_bits_d    = i_data_bits;
               cfg_par_en_d  = i_parity_en;
               cfg_par_odd_d = i_parity_odd;
               cfg_stop2_d   = i_stop_bits;
            end
         end
         ST_START: begin
            if (mid_sample) begin
               // A line back at 1 by mid-bit was a glitch, not a start bit
               state_d = rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (mid_sample) begin
               shift_d[bit_cnt_q] = rx_s;
               par_acc_d          = par_acc_q ^ rx_s;
               if (bit_cnt_q == last_bit) begin
                  state_d = cfg_par_en_q ? ST_PARITY : ST_STOP1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         ST_PARITY: begin
            if (mid_sample) begin
               if (rx_s != (par_acc_q ^ cfg_par_odd_q)) begin
                  par_err_d = 1'b1;
               end
               state_d = ST_STOP1;
            end
         end
         ST_STOP1: begin
            if (mid_sample) begin
               frm_err_d = frm_err_q | ~rx_s;
               if (cfg_stop2_q) begin
                  state_d = ST_STOP2;
               end else begin
                  complete = 1'b1;
               end
            end
         end
         ST_STOP2: begin
            if (mid_sample) begin
               frm_err_d = frm_err_q | ~rx_s;
               complete  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (complete) begin
         // Report immediately and return to IDLE so the next edge can be caught
         state_d    = ST_IDLE;
         valid_d    = 1'b1;
         data_d     = shift_q;
         perr_out_d = par_err_q;
         ferr_out_d = frm_err_q | ~rx_s;
         div_cnt_d  = '0;
         phase_d    = '0;
      end

      if (!i_enable) begin
         // Disabled receiver drops any partial frame and stays silent
         state_d    = ST_IDLE;
         div_cnt_d  = '0;
         phase_d    = '0;
         bit_cnt_d  = '0;
         data_d     = data_q;
         valid_d    = 1'b0;
         perr_out_d = 1'b0;
         ferr_out_d = 1'b0;
      end
   end

   assign o_data         = data_q;
   assign o_valid        = valid_q;
   assign o_parity_error = perr_out_q;
   assign o_bad_frame    = ferr_out_q;
   assign o_busy         = (state_q != ST_IDLE);

`ifdef UART_RX_IDLE_TIMEOUT_EN
   logic [7:0] to_cnt_q, to_cnt_d;
   logic       to_armed_q, to_armed_d;
   logic       timeout_q, timeout_d;

   // Count whole idle bit periods with the line high, armed by each received word
   always_comb begin
      to_cnt_d   = to_cnt_q;
      to_armed_d = to_armed_q;
      timeout_d  = 1'b0;

      if (valid_d) begin
         to_armed_d = 1'b1;
         to_cnt_d   = '0;
      end else if (start_edge || !rx_s) begin
         to_cnt_d = '0;
      end else if ((state_q == ST_IDLE) && to_armed_q && (i_timeout_bits != 8'd0)
                   && tick && (phase_q == LAST)) begin
         if (8'(to_cnt_q + 8'd1) == i_timeout_bits) begin
            timeout_d  = 1'b1;
            to_armed_d = 1'b0;
            to_cnt_d   = '0;
         end else begin
            to_cnt_d = to_cnt_q + 8'd1;
         end
      end

      if (!i_enable) begin
         to_cnt_d  = '0;
         timeout_d = 1'b0;
      end
   end

   // Timeout counter and pulse registers
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         to_cnt_q   <= '0;
         to_armed_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         to_cnt_q   <= to_cnt_d;
         to_armed_q <= to_armed_d;
         timeout_q  <= timeout_d;
      end
   end

   assign o_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: scenario tasks drive serial frames, push the expected
// word/flags to a queue, and compare against what the output monitor captured.
`timescale 1ns/1ps
module tb_uart_rx;
   localparam int DIV_WIDTH = 16;
   localparam int OVS       = 16;

   logic                 clk = 1'b0;
   logic                 nrst = 1'b0;
   logic                 rx = 1'b1;
   logic                 enable = 1'b0;
   logic [DIV_WIDTH-1:0] baud_div = '0;
   logic [1:0]           data_bits = 2'b11;
   logic                 parity_en = 1'b0;
   logic                 parity_odd = 1'b0;
   logic                 stop_bits = 1'b0;
   logic [7:0]           data;
   logic                 valid, perr, ferr, busy;
`ifdef UART_RX_IDLE_TIMEOUT_EN
   logic [7:0]           timeout_bits = 8'd0;
   logic                 timeout;
`endif

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } res_t;

   res_t  exp_q[$];
   res_t  obs_q[$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    stray = 0;
   int    timeout_cnt = 0;
   time   t_valid = 0;
   time   t_to = 0;
   logic  valid_prev = 1'b0;

   always #5 clk = ~clk;

   uart_rx #(
      .DIV_WIDTH(DIV_WIDTH),
      .OVS(OVS),
      .SYNC_STAGES(2)
   ) dut (
      .i_clk(clk),
      .i_nrst(nrst),
      .i_rx(rx),
      .i_enable(enable),
      .i_baud_div(baud_div),
      .i_data_bits(data_bits),
      .i_parity_en(parity_en),
      .i_parity_odd(parity_odd),
      .i_stop_bits(stop_bits),
      .o_data(data),
      .o_valid(valid),
      .o_parity_error(perr),
      .o_bad_frame(ferr),
      .o_busy(busy)
`ifdef UART_RX_IDLE_TIMEOUT_EN
      ,
      .i_timeout_bits(timeout_bits),
      .o_timeout(timeout)
`endif
   );

   // Output monitor: capture every completion, flag pulses that are too long or uncoupled
   always @(negedge clk) begin
      if (valid) begin
         obs_q.push_back({data, perr, ferr});
         t_valid = $time;
      end
      if (valid && valid_prev) stray++;
      if (!valid && (perr || ferr)) stray++;
      valid_prev = valid;
`ifdef UART_RX_IDLE_TIMEOUT_EN
      if (timeout) begin
         timeout_cnt++;
         t_to = $time;
      end
`endif
   end

   task automatic set_cfg(input int div, input logic [1:0] db, input bit pen, input bit podd,
                          input bit two_stop);
      baud_div   = DIV_WIDTH'(div);
      data_bits  = db;
      parity_en  = pen;
      parity_odd = podd;
      stop_bits  = two_stop;
   endtask

   // Drive one frame; optionally push the expected result and scramble config mid-frame
   task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit podd,
                             input bit two_stop, input bit bad_par, input bit s1, input bit s2,
                             input int bclk, input bit mess_cfg, input bit expect_it);
      logic [7:0] m;
      logic       par;
      res_t       e;
      m   = 8'hFF >> (8 - nb);
      par = (^(d & m)) ^ podd ^ bad_par;
      if (expect_it) begin
         e.d  = d & m;
         e.pe = pen & bad_par;
         e.fe = !s1 || (two_stop && !s2);
         exp_q.push_back(e);
      end
      rx = 1'b0;
      repeat (bclk) @(negedge clk);
      if (mess_cfg) begin
         data_bits  = ~data_bits;
         parity_en  = ~parity_en;
         parity_odd = ~parity_odd;
         stop_bits  = ~stop_bits;
      end
      for (int i = 0; i < nb; i++) begin
         rx = d[i];
         repeat (bclk) @(negedge clk);
      end
      if (pen) begin
         rx = par;
         repeat (bclk) @(negedge clk);
      end
      rx = s1;
      repeat (bclk) @(negedge clk);
      if (two_stop) begin
         rx = s2;
         repeat (bclk) @(negedge clk);
      end
      rx = 1'b1;
      if (mess_cfg) begin
         data_bits  = ~data_bits;
         parity_en  = ~parity_en;
         parity_odd = ~parity_odd;
         stop_bits  = ~stop_bits;
      end
   endtask

   // Bounded wait for the next captured completion and its expected entry
   task automatic wait_result(output res_t o, output res_t e, output bit got);
      got = 1'b0;
      o   = '0;
      e   = '0;
      for (int i = 0; i < 4000 && obs_q.size() == 0; i++) @(negedge clk);
      if (obs_q.size() > 0) begin
         o   = obs_q.pop_front();
         got = 1'b1;
      end
      if (exp_q.size() > 0) e = exp_q.pop_front();
   endtask

   task automatic test_reset();
      nrst   = 1'b0;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({data, valid, perr, ferr, busy} !== 12'h000) begin
         n_err++;
         $display("FAIL reset_outputs: got %h want 000", {data, valid, perr, ferr, busy});
      end
      nrst = 1'b1;
      enable = 1'b1;
      repeat (30) @(negedge clk);
      n_cmp++;
      if ({data, valid, perr, ferr, busy} !== 12'h000 || obs_q.size() != 0) begin
         n_err++;
         $display("FAIL idle_after_reset: got %h obs=%0d want 000 obs=0",
                  {data, valid, perr, ferr, busy}, obs_q.size());
      end
      $display("reset: outputs checked in and after reset");
   endtask

   task automatic test_8n1();
      res_t o, e;
      bit   got;
      logic mid_busy;
      set_cfg(0, 2'b11, 0, 0, 0);
      repeat (5) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL busy_before: got %b want 0", busy);
      end
      fork
         send_frame(8'hA5, 8, 0, 0, 0, 0, 1, 1, 16, 0, 1);
         begin
            repeat (80) @(negedge clk);
            mid_busy = busy;
         end
      join
      n_cmp++;
      if (mid_busy !== 1'b1) begin
         n_err++;
         $display("FAIL busy_mid: got %b want 1", mid_busy);
      end
      wait_result(o, e, got);
      n_cmp++;
      if (!got || o !== e) begin
         n_err++;
         $display("FAIL 8n1_a5: got d=%h pe=%b fe=%b seen=%0b want d=%h pe=%b fe=%b",
                  o.d, o.pe, o.fe, got, e.d, e.pe, e.fe);
      end
      $display("8n1: rx d=%h pe=%b fe=%b", o.d, o.pe, o.fe);
      repeat (2) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL busy_after: got %b want 0", busy);
      end
   endtask

   task automatic test_parity();
      res_t o, e;
      bit   got;
      set_cfg(0, 2'b11, 1, 0, 0);
      send_frame(8'h01, 8, 1, 0, 0, 1, 1, 1, 16, 0, 1);
      wait_result(o, e, got);
      n_cmp++;
      if (!got || o !== e) begin
         n_err++;
         $display("FAIL 8e1_badpar: got d=%h pe=%b fe=%b seen=%0b want d=%h pe=%b fe=%b",
                  o.d, o.pe, o.fe, got, e.d, e.pe, e.fe);
      end
      $display("8e1 bad parity: rx d=%h pe=%b fe=%b", o.d, o.pe, o.fe);
      send_frame(8'h03, 8, 1, 0, 0, 0, 1, 1, 16, 0, 1);
      wait_result(o, e, got);
      n_cmp++;
      if (!got || o !== e) begin
         n_err++;
         $display("FAIL 8e1_goodpar: got d=%h pe=%b fe=%b seen=%0b want d=%h pe=%b fe=%b",
                  o.d, o.pe, o.fe, got, e.d, e.pe, e.fe);
      end
      $display("8e1 good parity: rx d=%h pe=%b fe=%b", o.d, o.pe, o.fe);
      repeat (16) @(negedge clk);
   endtask

   task automatic test_frame_error();
      res_t o, e;
      bit   got;
      set_cfg(0, 2'b11, 0, 0, 0);
      send_frame(8'h7E, 8, 0, 0, 0, 0, 0, 1, 16, 0, 1);
      rx = 1'b0;
      wait_result(o, e, got);
      n_cmp++;
      if (!got || o !== e) begin
         n_err++;
         $display("FAIL 8n1_badstop: got d=%h pe=%b fe=%b seen=%0b want d=%h pe=%b fe=%b",
                  o.d, o.pe, o.fe, got, e.d, e.pe, e.fe);
      end
      $display("bad stop: rx d=%h pe=%b fe=%b", o.d, o.pe, o.fe);
      repeat (48) @(negedge clk);
      n_cmp++;
      if (obs_q.size() != 0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL held_low: got obs=%0d busy=%b want obs=0 busy=0", obs_q.size(), busy);
      end
      rx = 1'b1;
      repeat (16) @(negedge clk);
      send_frame(8'h3C, 8, 0, 0, 0, 0, 1, 1, 16, 0, 1);
      wait_result(o, e, got);
      n_cmp++;
      if (!got || o !== e) begin
         n_err++;
         $display("FAIL after_low: got d=%h pe=%b fe=%b seen=%0b want d=%h pe=%b fe=%b",
                  o.d, o.pe, o.fe, got, e.d, e.pe, e.fe);
      end
      $display("after low line: rx d=%h pe=%b fe=%b", o.d, o.pe, o.fe);
      repeat (16) @(negedge clk);
   endtask

   task automatic test_break();
      res_t o, e;
      bit   got;
      set_cfg(0, 2'b11, 0, 0, 0);
      send_frame(8'h00, 8, 0, 0, 0, 0, 0, 1, 16, 0, 1);
      wait_result(o, e, got);
      n_cmp++;
      if (!got || o !== e) begin
         n_err++;
         $display("FAIL break_8n1: got d=%h pe=%b fe=%b seen=%0b want d=%h pe=%b fe=%b",
                  o.d, o.pe, o.fe, got, e.d, e.pe, e.fe);
      end
      $display("break 8n1: rx d=%h pe=%b fe=%b", o.d, o.pe, o.fe);
      repeat (16) @(negedge clk);
      // odd parity over all-zero data wants a 1, so an all-zero line is a parity error too
      set_cfg(0, 2'b11, 1, 1, 0);
      send_frame(8'h00, 8, 1, 1, 0, 1, 0, 1, 16, 0, 1);
      wait_result(o, e, got);
      n_cmp++;
      if (!got || o !== e) begin
         n_err++;
         $display("FAIL break_8o1: got d=%h pe=%b fe=%b seen=%0b want d=%h pe=%b fe=%b",
                  o.d, o.pe, o.fe, got, e.d, e.pe, e.fe);
      end
      $display("break 8o1: rx d=%h pe=%b fe=%b", o.d, o.pe, o.fe);
      repeat (16) @(negedge clk);
   endtask

   task automatic test_false_start();
      set_cfg(0, 2'b11, 0, 0, 0);
      repeat (4) @(negedge clk);
      rx = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL glitch_busy: got %b want 1", busy);
      end
      rx = 1'b1;
      repeat (16) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL glitch_busy_clear: got %b want 0", busy);
      end
      repeat (40) @(negedge clk);
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_err++;
         $display("FAIL glitch_no_valid: got %0d words want 0", obs_q.size());
      end
      $display("false start: busy=%b words=%0d", busy, obs_q.size());
   endtask

   task automatic test_5o2();
      res_t o, e;
      bit   got;
      set_cfg(3, 2'b00, 1, 1, 1);
      repeat (8) @(negedge clk);
      send_frame(8'h15, 5, 1, 1, 1, 0, 1, 1, 64, 0, 1);
      wait_result(o, e, got);
      n_cmp++;
      if (!got || o !== e) begin
         n_err++;
         $display("FAIL 5o2_good: got d=%h pe=%b fe=%b seen=%0b want d=%h pe=%b fe=%b",
                  o.d, o.pe, o.fe, got, e.d, e.pe, e.fe);
      end
      $display("5o2: rx d=%h pe=%b fe=%b", o.d, o.pe, o.fe);
      repeat (64) @(negedge clk);
      send_frame(8'h15, 5, 1, 1, 1, 0, 1, 0, 64, 0, 1);
      wait_result(o, e, got);
      n_cmp++;
      if (!got || o !== e) begin
         n_err++;
         $display("FAIL 5o2_badstop2: got d=%h pe=%b fe=%b seen=%0b want d=%h pe=%b fe=%b",
                  o.d, o.pe, o.fe, got, e.d, e.pe, e.fe);
      end
      $display("5o2 bad stop2: rx d=%h pe=%b fe=%b", o.d, o.pe, o.fe);
      repeat (64) @(negedge clk);
   endtask

   task automatic test_config_latch();
      res_t o, e;
      bit   got;
      set_cfg(0, 2'b11, 0, 0, 0);
      repeat (4) @(negedge clk);
      send_frame(8'hC3, 8, 0, 0, 0, 0, 1, 1, 16, 1, 1);
      wait_result(o, e, got);
      n_cmp++;
      if (!got || o !== e) begin
         n_err++;
         $display("FAIL cfg_latch: got d=%h pe=%b fe=%b seen=%0b want d=%h pe=%b fe=%b",
                  o.d, o.pe, o.fe, got, e.d, e.pe, e.fe);
      end
      $display("config latch: rx d=%h pe=%b fe=%b", o.d, o.pe, o.fe);
      repeat (16) @(negedge clk);
   endtask

   task automatic test_enable();
      res_t o, e;
      bit   got;
      logic b_on, b_off;
      set_cfg(0, 2'b11, 0, 0, 0);
      fork
         send_frame(8'h99, 8, 0, 0, 0, 0, 1, 1, 16, 0, 0);
         begin
            repeat (48) @(negedge clk);
            b_on   = busy;
            enable = 1'b0;
            @(negedge clk);
            b_off  = busy;
         end
      join
      n_cmp++;
      if (b_on !== 1'b1 || b_off !== 1'b0) begin
         n_err++;
         $display("FAIL enable_drop: got busy %b->%b want 1->0", b_on, b_off);
      end
      repeat (16) @(negedge clk);
      enable = 1'b1;
      repeat (16) @(negedge clk);
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_err++;
         $display("FAIL enable_discard: got %0d words want 0", obs_q.size());
      end
      send_frame(8'h66, 8, 0, 0, 0, 0, 1, 1, 16, 0, 1);
      wait_result(o, e, got);
      n_cmp++;
      if (!got || o !== e) begin
         n_err++;
         $display("FAIL enable_recover: got d=%h pe=%b fe=%b seen=%0b want d=%h pe=%b fe=%b",
                  o.d, o.pe, o.fe, got, e.d, e.pe, e.fe);
      end
      $display("enable recover: rx d=%h pe=%b fe=%b", o.d, o.pe, o.fe);
      repeat (16) @(negedge clk);
   endtask

   task automatic test_async_reset();
      res_t       o, e;
      bit         got;
      logic [7:0] v;
      set_cfg(0, 2'b11, 0, 0, 0);
      v  = 8'h5A;
      rx = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx = v[i];
         repeat (16) @(negedge clk);
      end
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL mid_frame_busy: got %b want 1", busy);
      end
      #2 nrst = 1'b0;
      #1;
      n_cmp++;
      if ({data, valid, perr, ferr, busy} !== 12'h000) begin
         n_err++;
         $display("FAIL async_reset: got %h want 000", {data, valid, perr, ferr, busy});
      end
      rx = 1'b1;
      repeat (4) @(negedge clk);
      nrst = 1'b1;
      repeat (20) @(negedge clk);
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_err++;
         $display("FAIL reset_no_valid: got %0d words want 0", obs_q.size());
      end
      send_frame(8'h5A, 8, 0, 0, 0, 0, 1, 1, 16, 0, 1);
      wait_result(o, e, got);
      n_cmp++;
      if (!got || o !== e) begin
         n_err++;
         $display("FAIL after_reset: got d=%h pe=%b fe=%b seen=%0b want d=%h pe=%b fe=%b",
                  o.d, o.pe, o.fe, got, e.d, e.pe, e.fe);
      end
      $display("after async reset: rx d=%h pe=%b fe=%b", o.d, o.pe, o.fe);
      repeat (16) @(negedge clk);
   endtask

`ifdef UART_RX_IDLE_TIMEOUT_EN
   task automatic test_timeout();
      res_t o, e;
      bit   got;
      int   before;
      time  lat;
      set_cfg(0, 2'b11, 0, 0, 0);
      timeout_bits = 8'd4;
      before = timeout_cnt;
      send_frame(8'h81, 8, 0, 0, 0, 0, 1, 1, 16, 0, 1);
      wait_result(o, e, got);
      n_cmp++;
      if (!got || o !== e) begin
         n_err++;
         $display("FAIL timeout_word: got d=%h pe=%b fe=%b seen=%0b want d=%h pe=%b fe=%b",
                  o.d, o.pe, o.fe, got, e.d, e.pe, e.fe);
      end
      repeat (16 * 12) @(negedge clk);
      lat = t_to - t_valid;
      n_cmp++;
      if (timeout_cnt - before != 1) begin
         n_err++;
         $display("FAIL timeout_count: got %0d pulses want 1", timeout_cnt - before);
      end
      n_cmp++;
      if (lat < 600 || lat > 680) begin
         n_err++;
         $display("FAIL timeout_latency: got %0t want about 640 (4 bit times)", lat);
      end
      $display("timeout: pulses=%0d latency=%0t", timeout_cnt - before, lat);
      timeout_bits = 8'd0;
   endtask
`endif

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_frame_error();
      test_break();
      test_false_start();
      test_5o2();
      test_config_latch();
      test_enable();
      test_async_reset();
`ifdef UART_RX_IDLE_TIMEOUT_EN
      test_timeout();
`endif
      n_cmp++;
      if (stray != 0) begin
         n_err++;
         $display("FAIL pulse_shape: got %0d malformed pulses want 0", stray);
      end
      n_cmp++;
      if (exp_q.size() != 0 || obs_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got exp=%0d obs=%0d want 0/0", exp_q.size(), obs_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
